apb3_completer_fifo: RTL and testbench

APB3_COMPLETER_FIFO -- requirements
Module: apb3_completer_fifo

---
 rtl/apb3_completer_fifo_pkg.sv | 18 +
 rtl/apb3_completer_fifo_fifo_sync.sv | 73 +++++++
 rtl/apb3_completer_fifo.sv | 159 +++++++++++++++
 tb/tb_apb3_completer_fifo.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb3_completer_fifo_pkg.sv
// Shared register map, STATUS bit positions and FSM state type for the APB3 FIFO completer.
package apb3_completer_fifo_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_LEVEL  = 2'd3;

  localparam int STATUS_EMPTY_BIT = 0;
  localparam int STATUS_FULL_BIT  = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb3_completer_fifo_fifo_sync.sv
// Single-clock FIFO with wrapping pointers and an explicit level counter.
module fifo_sync #(
  parameter int Width = 32,
  parameter int Depth = 8,
  localparam int PtrW = $clog2(Depth),
  localparam int LvlW = $clog2(Depth) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LvlW-1:0]  level
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic             do_push, do_pop;

  assign full  = (level_q == LvlW'(Depth));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      // Depth is a power of two, so pointer overflow is the modulo wrap.
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      level_d = level_q + LvlW'(do_push) - LvlW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is deliberately left unreset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/apb3_completer_fifo.sv
// APB3 completer exposing a FIFO through DATA/STATUS/CTRL/LEVEL registers, with programmable wait states.
module apb3_completer_fifo
  import apb3_completer_fifo_pkg::*;
#(
  parameter int AddressWidth = 20,
  parameter int DataWidth    = 32,
  parameter int Depth        = 8,
  parameter int WaitStates   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [AddressWidth-1:0] paddr,
  input  logic                    pwrite,
  input  logic                    psel,
  input  logic                    penable,
  input  logic [DataWidth-1:0]    pwdata,
  output logic [DataWidth-1:0]    prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int LvlW = $clog2(Depth) + 1;
  localparam logic [3:0] WaitInit = 4'(WaitStates);

  apb_state_e           state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 pready_q, pready_d;
  logic                 pslverr_q, pslverr_d;
  logic [DataWidth-1:0] prdata_q, prdata_d;

  logic                 mapped;
  logic [1:0]           reg_sel;
  logic                 commit;
  logic                 fifo_push, fifo_pop, fifo_flush;
  logic                 fifo_full, fifo_empty;
  logic [DataWidth-1:0] fifo_rdata;
  logic [LvlW-1:0]      fifo_level;
  logic [DataWidth-1:0] rsp_data;
  logic                 rsp_err;
  logic                 unused_addr_lsb;

  assign mapped          = (paddr[AddressWidth-1:4] == '0);
  assign reg_sel         = paddr[3:2];
  assign unused_addr_lsb = ^paddr[1:0];

  assign commit     = (state_q == ST_RESP) && psel && penable;
  assign fifo_push  = commit && mapped && pwrite && (reg_sel == REG_DATA);
  assign fifo_pop   = commit && mapped && !pwrite && (reg_sel == REG_DATA) && !fifo_empty;
  assign fifo_flush = commit && mapped && pwrite && (reg_sel == REG_CTRL) && pwdata[0];

  // Response is captured when entering RESP; the FIFO cannot change before then.
  always_comb begin
    rsp_data = '0;
    rsp_err  = 1'b0;
    if (!mapped) begin
      rsp_err = 1'b1;
    end else begin
      case (reg_sel)
        REG_DATA: begin
          if (pwrite)          rsp_err = fifo_full;
          else if (fifo_empty) rsp_err = 1'b1;
          else                 rsp_data = fifo_rdata;
        end
        REG_STATUS: begin
          if (pwrite) begin
            rsp_err = 1'b1;
          end else begin
            rsp_data[STATUS_EMPTY_BIT] = fifo_empty;
            rsp_data[STATUS_FULL_BIT]  = fifo_full;
          end
        end
        REG_LEVEL: begin
          if (pwrite) rsp_err = 1'b1;
          else        rsp_data = DataWidth'(fifo_level);
        end
        default: ;
      endcase
    end
    if (pwrite) rsp_data = '0;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (psel && !penable) begin
          if (WaitInit == 4'd0) begin
            state_d   = ST_RESP;
            pready_d  = 1'b1;
            pslverr_d = rsp_err;
            prdata_d  = rsp_data;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WaitInit;
          end
        end
      end
      ST_WAIT: begin
        if (!psel) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd1) begin
          state_d   = ST_RESP;
          cnt_d     = '0;
          pready_d  = 1'b1;
          pslverr_d = rsp_err;
          prdata_d  = rsp_data;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign prdata  = prdata_q;

  fifo_sync #(
    .Width (DataWidth),
    .Depth (Depth)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .wdata (pwdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_apb3_completer_fifo.sv
// Randomized bench for two completer instances (0 and 3 wait states) against a queue-based register model.
module tb_apb3_completer_fifo;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] paddr_s   [2];
  logic        pwrite_s  [2];
  logic        psel_s    [2];
  logic        penable_s [2];
  logic [31:0] pwdata_s  [2];
  logic [31:0] prdata_s  [2];
  logic        pready_s  [2];
  logic        pslverr_s [2];

  logic [31:0] q0 [$];
  logic [31:0] q1 [$];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  apb3_completer_fifo #(.AddressWidth(20), .DataWidth(32), .Depth(DEPTH), .WaitStates(0)) dut_ws0 (
    .clk(clk), .rst_n(rst_n), .paddr(paddr_s[0]), .pwrite(pwrite_s[0]), .psel(psel_s[0]),
    .penable(penable_s[0]), .pwdata(pwdata_s[0]), .prdata(prdata_s[0]), .pready(pready_s[0]),
    .pslverr(pslverr_s[0])
  );

  apb3_completer_fifo #(.AddressWidth(20), .DataWidth(32), .Depth(DEPTH), .WaitStates(3)) dut_ws3 (
    .clk(clk), .rst_n(rst_n), .paddr(paddr_s[1]), .pwrite(pwrite_s[1]), .psel(psel_s[1]),
    .penable(penable_s[1]), .pwdata(pwdata_s[1]), .prdata(prdata_s[1]), .pready(pready_s[1]),
    .pslverr(pslverr_s[1])
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One complete APB transfer on instance d, checked against the register model.
  task automatic xfer(input int d, input logic [19:0] addr, input logic wr, input logic [31:0] wd);
    logic [31:0] q [$];
    logic [31:0] exp_d;
    logic        exp_e;
    logic        do_push, do_pop, do_flush;
    int          n;
    int          ws;
    if (d == 0) q = q0; else q = q1;
    ws       = (d == 0) ? 0 : 3;
    exp_d    = 32'h0;
    exp_e    = 1'b0;
    do_push  = 1'b0;
    do_pop   = 1'b0;
    do_flush = 1'b0;
    if (addr[19:4] != 16'h0) begin
      exp_e = 1'b1;
    end else begin
      case (addr[3:2])
        2'd0: begin
          if (wr) begin
            if (q.size() == DEPTH) exp_e = 1'b1; else do_push = 1'b1;
          end else begin
            if (q.size() == 0) exp_e = 1'b1;
            else begin exp_d = q[0]; do_pop = 1'b1; end
          end
        end
        2'd1: begin
          if (wr) exp_e = 1'b1;
          else exp_d = {30'h0, q.size() == DEPTH, q.size() == 0};
        end
        2'd2: begin
          if (wr) do_flush = wd[0];
        end
        default: begin
          if (wr) exp_e = 1'b1; else exp_d = q.size();
        end
      endcase
    end

    @(posedge clk); #1;
    check_eq("pready_one_cycle", pready_s[d], 1'b0);
    paddr_s[d]   = addr;
    pwrite_s[d]  = wr;
    pwdata_s[d]  = wd;
    psel_s[d]    = 1'b1;
    penable_s[d] = 1'b0;
    @(posedge clk); #1;
    penable_s[d] = 1'b1;
    n = 1;
    while (!pready_s[d] && n < 40) begin
      check_eq("quiet_while_waiting", {prdata_s[d], pslverr_s[d]}, 33'h0);
      @(posedge clk); #1;
      n++;
    end
    if (!pready_s[d]) begin
      check_eq("pready_timeout", pready_s[d], 1'b1);
    end else begin
      check_eq("latency", n, ws + 1);
      check_eq("pslverr", pslverr_s[d], exp_e);
      if (!wr) check_eq("prdata", prdata_s[d], exp_d);
    end

    if (do_flush) q.delete();
    if (do_push) q.push_back(wd);
    if (do_pop) void'(q.pop_front());
    if (d == 0) q0 = q; else q1 = q;
  endtask

  task automatic idle_bus();
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      psel_s[i]    = 1'b0;
      penable_s[i] = 1'b0;
    end
  endtask

  function automatic logic [19:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0, 1, 2, 3: return 20'h00000;
      4:          return 20'h00004;
      5:          return 20'h00008;
      6:          return 20'h0000C;
      7:          return 20'(($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
      8:          return 20'h00010 + 20'($urandom_range(0, 15));
      default:    return 20'($urandom_range(16, 20'hFFFFF));
    endcase
  endfunction

  initial begin
    logic [31:0] wd;
    logic [19:0] a;
    int          d;
    logic        wr;

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      paddr_s[i]   = '0;
      pwrite_s[i]  = 1'b0;
      psel_s[i]    = 1'b0;
      penable_s[i] = 1'b0;
      pwdata_s[i]  = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check_eq("reset_pready", pready_s[i], 1'b0);
      check_eq("reset_pslverr", pslverr_s[i], 1'b0);
      check_eq("reset_prdata", prdata_s[i], 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    xfer(0, 20'h0, 1'b1, 32'hDEADBEEF);
    xfer(0, 20'hC, 1'b0, 32'h0);
    xfer(0, 20'h0, 1'b0, 32'h0);
    xfer(0, 20'hC, 1'b0, 32'h0);

    for (int i = 1; i <= 9; i++) xfer(0, 20'h0, 1'b1, 32'(i));
    xfer(0, 20'h4, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) xfer(0, 20'h0, 1'b0, 32'h0);
    xfer(0, 20'h4, 1'b0, 32'h0);

    xfer(0, 20'h0, 1'b0, 32'h0);
    xfer(0, 20'h0, 1'b1, 32'h55AA55AA);
    xfer(0, 20'h10, 1'b0, 32'h0);
    xfer(0, 20'h4, 1'b1, 32'hFFFFFFFF);
    xfer(0, 20'hC, 1'b0, 32'h0);

    xfer(0, 20'h0, 1'b1, 32'h11);
    xfer(0, 20'h0, 1'b1, 32'h22);
    xfer(0, 20'h8, 1'b1, 32'hFFFFFFFE);
    xfer(0, 20'hC, 1'b0, 32'h0);
    xfer(0, 20'h8, 1'b0, 32'h0);
    xfer(0, 20'h8, 1'b1, 32'h1);
    xfer(0, 20'hC, 1'b0, 32'h0);
    xfer(0, 20'h4, 1'b0, 32'h0);
    idle_bus();

    for (int i = 0; i < 16; i++) begin
      xfer(1, 20'h0, 1'b1, $urandom);
      xfer(1, 20'h0, 1'b0, 32'h0);
    end
    idle_bus();

    for (int i = 0; i < 300; i++) begin
      d  = $urandom_range(0, 1);
      a  = rand_addr();
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      if (a == 20'h8) wd[0] = ($urandom_range(0, 7) == 0);
      xfer(d, a, wr, wd);
      if ($urandom_range(0, 7) == 0) idle_bus();
    end
    idle_bus();

    xfer(1, 20'h8, 1'b1, 32'h1);
    for (int i = 0; i < 3; i++) xfer(1, 20'h0, 1'b1, 32'hA0 + 32'(i));
    xfer(1, 20'hC, 1'b0, 32'h0);
    @(posedge clk); #1;
    paddr_s[1]   = 20'h0;
    pwrite_s[1]  = 1'b0;
    psel_s[1]    = 1'b1;
    penable_s[1] = 1'b0;
    @(posedge clk); #1;
    penable_s[1] = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_pready", pready_s[1], 1'b0);
    check_eq("rst_mid_pslverr", pslverr_s[1], 1'b0);
    check_eq("rst_mid_prdata", prdata_s[1], 32'h0);
    psel_s[1]    = 1'b0;
    penable_s[1] = 1'b0;
    psel_s[0]    = 1'b0;
    penable_s[0] = 1'b0;
    q0.delete();
    q1.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    xfer(1, 20'hC, 1'b0, 32'h0);
    xfer(1, 20'h4, 1'b0, 32'h0);
    xfer(0, 20'hC, 1'b0, 32'h0);
    idle_bus();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
